demux_fourtoone: RTL and testbench

DEMUX_FOURTOONE -- requirements
Module: demux_fourtoone

---
 rtl/demux_fourtoone.sv | 57 +++++
 tb/tb_demux_fourtoone.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/demux_fourtoone.sv
// rtl/demux_fourtoone.sv - 1-to-4 lane demultiplexer with registered copies and sticky lane-hit flags
module demux_fourtoone #(
  parameter int DATA_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     D00,
  input  logic [1:0]            s,
  output logic [4*DATA_W-1:0]   y,
  output logic [4*DATA_W-1:0]   y_q,
  output logic [1:0]            sel_q,
  output logic [3:0]            lane_hit
);

  logic [4*DATA_W-1:0] y_hold_q;
  logic [1:0]          sel_hold_q;
  logic [3:0]          hit_q;
  logic [3:0]          hit_d;

  // Route D00 onto the selected lane; unknown selects drive nothing.
  always_comb begin
    y = '0;
    case (s)
      2'b00:   y[0*DATA_W +: DATA_W] = D00;
      2'b01:   y[1*DATA_W +: DATA_W] = D00;
      2'b10:   y[2*DATA_W +: DATA_W] = D00;
      2'b11:   y[3*DATA_W +: DATA_W] = D00;
      default: y = '0;
    endcase
  end

  // Sticky flags: only the selected lane can set, and only with non-zero data.
  always_comb begin
    hit_d = hit_q;
    if (D00 != '0) begin
      hit_d[s] = 1'b1;
    end
  end

  // Registered copies and flags; reset wins over capture on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_hold_q   <= '0;
      sel_hold_q <= 2'b00;
      hit_q      <= 4'b0000;
    end else begin
      y_hold_q   <= y;
      sel_hold_q <= s;
      hit_q      <= hit_d;
    end
  end

  assign y_q      = y_hold_q;
  assign sel_q    = sel_hold_q;
  assign lane_hit = hit_q;

endmodule

// File: tb/tb_demux_fourtoone.sv
// tb/tb_demux_fourtoone.sv - directed self-checking bench for demux_fourtoone
module tb_demux_fourtoone;

  logic        clk;
  logic        rst;
  logic [0:0]  d1;
  logic [1:0]  s1;
  logic [3:0]  y1, yq1;
  logic [1:0]  selq1;
  logic [3:0]  hit1;
  logic [3:0]  d4;
  logic [1:0]  s4;
  logic [15:0] y4, yq4;
  logic [1:0]  selq4;
  logic [3:0]  hit4;

  int n_pass;
  int n_total;

  demux_fourtoone #(.DATA_W(1)) dut1 (
    .clk(clk), .rst(rst), .D00(d1), .s(s1),
    .y(y1), .y_q(yq1), .sel_q(selq1), .lane_hit(hit1)
  );

  demux_fourtoone #(.DATA_W(4)) dut4 (
    .clk(clk), .rst(rst), .D00(d4), .s(s4),
    .y(y4), .y_q(yq4), .sel_q(selq4), .lane_hit(hit4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    d1 = 1'b0; s1 = 2'b00;
    d4 = 4'h0; s4 = 2'b00;
    step();
    step();
    check("rst_yq", {12'h0, yq1}, 16'h0000);
    check("rst_selq", {14'h0, selq1}, 16'h0000);
    check("rst_hit", {12'h0, hit1}, 16'h0000);
    check("rst_yq_w4", yq4, 16'h0000);

    // combinational sweep while reset is held
    d1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s1 = k[1:0];
      #1;
      check($sformatf("sweep_s%0d", k), {12'h0, y1}, 16'h0001 << k);
    end

    // reset edge with data on lane 3: nothing captured
    step();
    check("rst_edge_hit", {12'h0, hit1}, 16'h0000);
    check("rst_edge_yq", {12'h0, yq1}, 16'h0000);
    rst = 1'b0;
    step();
    check("post_rst_hit", {12'h0, hit1}, 16'h0008);
    check("post_rst_yq", {12'h0, yq1}, 16'h0008);
    check("post_rst_selq", {14'h0, selq1}, 16'h0003);

    // clear again, then zero data on lane 2
    rst = 1'b1;
    step();
    check("clr_hit", {12'h0, hit1}, 16'h0000);
    rst = 1'b0;
    d1 = 1'b0; s1 = 2'b10;
    #1;
    check("zero_data_y", {12'h0, y1}, 16'h0000);
    step();
    check("zero_data_yq", {12'h0, yq1}, 16'h0000);
    check("zero_data_selq", {14'h0, selq1}, 16'h0002);
    check("zero_data_hit", {12'h0, hit1}, 16'h0000);

    d1 = 1'b1; s1 = 2'b01;
    step();
    check("lane1_yq", {12'h0, yq1}, 16'h0002);
    check("lane1_selq", {14'h0, selq1}, 16'h0001);
    check("lane1_hit", {12'h0, hit1}, 16'h0002);
    d1 = 1'b0; s1 = 2'b11;
    step();
    check("lane3_zero_yq", {12'h0, yq1}, 16'h0000);
    check("lane3_zero_hit", {12'h0, hit1}, 16'h0002);

    d1 = 1'b1; s1 = 2'b01;
    step();
    step();
    check("repeat_hit", {12'h0, hit1}, 16'h0002);
    s1 = 2'b10;
    step();
    check("lane2_hit", {12'h0, hit1}, 16'h0006);
    check("lane2_yq", {12'h0, yq1}, 16'h0004);

    // select changes between edges
    s1 = 2'b00;
    #1;
    check("midcycle_y", {12'h0, y1}, 16'h0001);
    check("midcycle_yq_held", {12'h0, yq1}, 16'h0004);
    s1 = 2'b11;
    step();
    check("late_sel_yq", {12'h0, yq1}, 16'h0008);
    check("late_sel_selq", {14'h0, selq1}, 16'h0003);
    check("late_sel_hit", {12'h0, hit1}, 16'h000E);

    // wide lanes
    d4 = 4'hA; s4 = 2'b10;
    #1;
    check("w4_y", y4, 16'h0A00);
    step();
    check("w4_yq", yq4, 16'h0A00);
    d4 = 4'hF; s4 = 2'b11;
    #1;
    check("w4_y_lane3", y4, 16'hF000);
    step();
    check("w4_yq_lane3", yq4, 16'hF000);
    check("w4_hit", {12'h0, hit4}, 16'h000C);

    // mid-operation reset, then resume
    rst = 1'b1;
    d1 = 1'b1; s1 = 2'b00;
    #1;
    check("rst_y_follow", {12'h0, y1}, 16'h0001);
    step();
    check("mid_rst_hit", {12'h0, hit1}, 16'h0000);
    check("mid_rst_yq", {12'h0, yq1}, 16'h0000);
    check("mid_rst_w4_hit", {12'h0, hit4}, 16'h0000);
    rst = 1'b0;
    step();
    check("resume_hit", {12'h0, hit1}, 16'h0001);
    check("resume_yq", {12'h0, yq1}, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
